pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side sequencer for the 9-bit processor. It owns the program counter and runs the Start/Done handshake with the test harness. It consumes `branch_en` from the control decoder and the current instruction word, resolves branch targets through a small writable target table, and stops on the halt instruction. It sits between the harness, the instruction ROM (driven by `PC`) and the control decoder.

## Interface
Parameters:
- `PC_W`, default 10: program counter width. Instruction ROM depth is 2^PC_W.
- `START_ADDR`, default 0: value loaded into `PC` on Start.
- `CNT_W`, default 16: width of the cycle counter.

Ports:
- `Clk`, input, 1: single clock. All state updates on the rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Start`, input, 1: request to begin execution. Sampled in IDLE and DONE only.
- `Instruction`, input, 9: instruction word currently read at `PC`.
- `branch_en`, input, 1: taken-branch indication from the control decoder, for the current `Instruction`.
- `stall`, input, 1: freezes `PC` for this cycle.
- `cfg_we`, input, 1: target-table write enable.
- `cfg_idx`, input, 4: target-table write index.
- `cfg_target`, input, PC_W: target-table write data, an absolute address.
- `PC`, output, PC_W: fetch address.
- `busy`, output, 1: high while in RUN.
- `Done`, output, 1: high while in DONE.
- `cycle_count`, output, CNT_W: number of RUN cycles since the last Start.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **Reset values:** state IDLE, `PC`=0, `busy`=0, `Done`=0, `cycle_count`=0, all 16 table entries = 0.
- **IDLE:**
  - `Start`=1: `PC`←START_ADDR, `cycle_count`←0, go to RUN.
  - Otherwise hold all values.
- **RUN, every cycle:** `cycle_count`←`cycle_count`+1. The counter saturates at 2^CNT_W−1 and does not wrap.
- **RUN, `stall`=1:** `PC` holds. Halt and branch are not evaluated.
- **RUN, `stall`=0,** evaluated in priority order:
  1. `Instruction`==kHALT: `PC` holds and the FSM goes to DONE.
  2. `branch_en`=1: `PC`←table[`Instruction[3:0]`].
  3. Otherwise: `PC`←`PC`+1, modulo 2^PC_W. The address 2^PC_W−1 wraps to 0.
- **Start during RUN** is ignored.
- **DONE:**
  - `PC` and `cycle_count` hold.
  - `Start`=1: reload as from IDLE and go to RUN. `Done` falls on the same edge.
- **Target table:**
  - `cfg_we`=1 writes `cfg_target` to entry `cfg_idx` at the clock edge. Writes are accepted in any state.
  - A branch read and a write to the same index in the same cycle: the branch uses the old value. The new value is visible from the next cycle on.
- **Reset mid-RUN:** everything returns to the reset values immediately (asynchronous), including the table contents.

## Timing
- `PC`, `busy`, `Done` and `cycle_count` are registered. No combinational path runs from any input to any output.
- **Start:**
  - `Start` is sampled high at edge N.
  - `PC`=START_ADDR and `busy`=1 from edge N onward.
  - The first instruction is evaluated in the cycle after edge N.
- **Branch latency:** one cycle. `branch_en` high before edge N gives `PC`=target after edge N, with no bubble.
- **Halt:**
  - kHALT is present before edge N.
  - After edge N: `Done`=1, `busy`=0, `PC` = the halt address.
- **cycle_count:**
  - Counts the cycle in which halt is evaluated.
  - Counts stall cycles.
  - A program of k non-stalled instructions ending in halt gives `cycle_count`=k+1, where k excludes the halt itself.
- **Restart:** `Start` in DONE behaves identically to `Start` in IDLE. `Start` held high for multiple cycles restarts only once per exit from RUN.

## Structure
- **Shared `definitions` package additions:**
  - `kHALT` = 9'h1FF.
  - `kLUT_IDX_W` = 4.
  - Enum `pc_state_t` with values {IDLE, RUN, DONE}.
- **Sub-module `branch_lut`:**
  - 16 × PC_W registers.
  - One synchronous write port and one combinational read port.
  - Asynchronous clear on `Reset`.
- The top level holds the FSM, the `PC` register, the incrementer and the saturating counter.

## Test plan
- **Reset and linear run:**
  - Stimulus: reset, then `Start` for 1 cycle; ROM = NOPs at 0..4 and kHALT at 5.
  - Required: `PC` steps 0,1,2,3,4,5; `Done`=1 one edge after `PC`=5; `PC` stays 5; `cycle_count`=6.
- **Taken branch:**
  - Stimulus: write table[3]=0x020; at `PC`=2 present an instruction with `[3:0]`=3 and `branch_en`=1.
  - Required: next `PC`=0x020. With `branch_en`=0 instead, next `PC`=3.
- **Stall:**
  - Stimulus: `stall`=1 for 3 cycles at `PC`=4, with kHALT present during the stall.
  - Required: `PC` stays 4 and no halt occurs; `cycle_count` advances 3; after `stall` drops, halt happens on the next edge.
- **Write/read collision:**
  - Stimulus: table[7]=0x010; in the same cycle, branch via index 7 and write 0x0AA to index 7.
  - Required: `PC`=0x010. A later branch via index 7 gives 0x0AA.
- **Wrap:**
  - Stimulus: START_ADDR = 2^PC_W−1, non-branch instruction.
  - Required: next `PC`=0.
- **Async reset and restart:**
  - Stimulus: assert `Reset` mid-RUN between clock edges.
  - Required: `PC`, `busy` and table contents go to 0 immediately.
  - Stimulus: `Start` in DONE.
  - Required: `PC`=START_ADDR, `Done`=0, `cycle_count`=0 after the edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the 9-bit processor fetch side: halt encoding,
// branch-table index width and the sequencer state encoding.
package definitions;

  // Instruction word that stops execution.
  localparam logic [8:0] kHALT      = 9'h1FF;

  // Width of the branch-target table index (low bits of the instruction).
  localparam int         kLUT_IDX_W = 4;
  localparam int         kLUT_DEPTH = 1 << kLUT_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-target table: 16 absolute addresses, one synchronous write port
// and one combinational read port, cleared asynchronously by Reset.
// A same-cycle write and read of one entry returns the old contents.
module branch_lut
  import definitions::*;
#(
  parameter int PC_W = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  we,
  input  logic [kLUT_IDX_W-1:0] widx,
  input  logic [PC_W-1:0]       wdata,
  input  logic [kLUT_IDX_W-1:0] ridx,
  output logic [PC_W-1:0]       rdata
);

  logic [PC_W-1:0] entry_val [kLUT_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < kLUT_DEPTH; gi++) begin : g_entry
      logic [PC_W-1:0] entry_reg;
      logic            wsel;

      assign wsel = we && (widx == kLUT_IDX_W'(gi));

      // Each entry loads on a matching write and clears on reset.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          entry_reg <= '0;
        end else if (wsel) begin
          entry_reg <= wdata;
        end
      end

      assign entry_val[gi] = entry_reg;
    end
  endgenerate

  // Read is a plain mux of the registered entries, so a write in the
  // same cycle is not seen until the following cycle.
  assign rdata = entry_val[ridx];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns the program counter, runs the Start/Done
// handshake, resolves taken branches through the target table and stops
// on the halt instruction. All outputs are registered.
module pc_sequencer
  import definitions::*;
#(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instruction,
  input  logic             branch_en,
  input  logic             stall,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [PC_W-1:0]  cfg_target,
  output logic [PC_W-1:0]  PC,
  output logic             busy,
  output logic             Done,
  output logic [CNT_W-1:0] cycle_count
);

  pc_state_t       state_reg;
  logic [PC_W-1:0] lut_target;
  logic            is_halt;

  assign is_halt = (Instruction == kHALT);

  branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (cfg_we),
    .widx  (cfg_idx),
    .wdata (cfg_target),
    .ridx  (Instruction[kLUT_IDX_W-1:0]),
    .rdata (lut_target)
  );

  // Sequencer FSM with PC, status flags and saturating RUN-cycle counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      PC          <= '0;
      busy        <= 1'b0;
      Done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // Restart from DONE is identical to a start from IDLE.
          if (Start) begin
            state_reg   <= RUN;
            PC          <= START_ADDR;
            cycle_count <= '0;
            busy        <= 1'b1;
            Done        <= 1'b0;
          end
        end
        RUN: begin
          // Every RUN cycle counts, including stalls and the halt cycle.
          if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
          // A stall freezes PC and masks halt/branch evaluation.
          if (!stall) begin
            if (is_halt) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              Done      <= 1'b1;
            end else if (branch_en) begin
              PC <= lut_target;
            end else begin
              PC <= PC + PC_W'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main program
// flows plus hand-written sequences for async reset, wrap and saturation.
module tb_pc_sequencer;

  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  Instruction;
  logic        branch_en;
  logic        stall;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [9:0]  cfg_target;

  logic [9:0]  pc1;
  logic        busy1;
  logic        done1;
  logic [15:0] cnt1;

  logic [9:0]  pc2;
  logic        busy2;
  logic        done2;
  logic [2:0]  cnt2;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Instruction (Instruction),
    .branch_en   (branch_en),
    .stall       (stall),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_target  (cfg_target),
    .PC          (pc1),
    .busy        (busy1),
    .Done        (done1),
    .cycle_count (cnt1)
  );

  // Second instance: start at the top of the address space, narrow counter.
  pc_sequencer #(
    .PC_W       (10),
    .START_ADDR (10'h3FF),
    .CNT_W      (3)
  ) dut_wrap (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Instruction (Instruction),
    .branch_en   (branch_en),
    .stall       (stall),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_target  (cfg_target),
    .PC          (pc2),
    .busy        (busy2),
    .Done        (done2),
    .cycle_count (cnt2)
  );

  typedef struct {
    logic        start;
    logic [8:0]  instr;
    logic        br;
    logic        stl;
    logic        we;
    logic [3:0]  idx;
    logic [9:0]  tgt;
    logic [9:0]  exp_pc;
    logic        exp_busy;
    logic        exp_done;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic [8:0] i, logic b, logic st,
                              logic w, logic [3:0] x, logic [9:0] t,
                              logic [9:0] p, logic bz, logic d, logic [15:0] c);
    vec_t v;
    v.start = s;  v.instr = i;  v.br = b;  v.stl = st;
    v.we = w;     v.idx = x;    v.tgt = t;
    v.exp_pc = p; v.exp_busy = bz; v.exp_done = d; v.exp_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [8:0] i, input logic b, input logic st,
                       input logic w, input logic [3:0] x, input logic [9:0] t);
    Start = s; Instruction = i; branch_en = b; stall = st;
    cfg_we = w; cfg_idx = x; cfg_target = t;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
    Reset = 1'b1;
    #12;
    check("reset_pc",   32'(pc1),   32'd0);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    check("reset_cnt",  32'(cnt1),  32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Linear run: PC 0..5, halt at 5, cycle_count 6.
    vq.push_back(mk(1, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h000, 1, 0, 16'd0));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h001, 1, 0, 16'd1));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h002, 1, 0, 16'd2));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h003, 1, 0, 16'd3));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h004, 1, 0, 16'd4));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h005, 1, 0, 16'd5));
    vq.push_back(mk(0, HALT,  0, 0, 0, 4'd0, 10'h000, 10'h005, 0, 1, 16'd6));
    vq.push_back(mk(0, HALT,  0, 0, 0, 4'd0, 10'h000, 10'h005, 0, 1, 16'd6));
    // Restart from DONE while writing table[3]=0x020, then branch via idx 3.
    vq.push_back(mk(1, NOP,   0, 0, 1, 4'd3, 10'h020, 10'h000, 1, 0, 16'd0));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h001, 1, 0, 16'd1));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h002, 1, 0, 16'd2));
    vq.push_back(mk(0, 9'h003,1, 0, 0, 4'd0, 10'h000, 10'h020, 1, 0, 16'd3));
    vq.push_back(mk(0, 9'h003,0, 0, 0, 4'd0, 10'h000, 10'h021, 1, 0, 16'd4));
    // Stall masks a branch, then three stalled halts, then the halt takes.
    vq.push_back(mk(0, 9'h003,1, 1, 0, 4'd0, 10'h000, 10'h021, 1, 0, 16'd5));
    vq.push_back(mk(0, HALT,  0, 1, 0, 4'd0, 10'h000, 10'h021, 1, 0, 16'd6));
    vq.push_back(mk(0, HALT,  0, 1, 0, 4'd0, 10'h000, 10'h021, 1, 0, 16'd7));
    vq.push_back(mk(0, HALT,  0, 1, 0, 4'd0, 10'h000, 10'h021, 1, 0, 16'd8));
    vq.push_back(mk(0, HALT,  0, 0, 0, 4'd0, 10'h000, 10'h021, 0, 1, 16'd9));
    // Restart writing table[7]=0x010; non-branch at PC=2 with idx 3 goes to 3.
    vq.push_back(mk(1, NOP,   0, 0, 1, 4'd7, 10'h010, 10'h000, 1, 0, 16'd0));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h001, 1, 0, 16'd1));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h002, 1, 0, 16'd2));
    vq.push_back(mk(0, 9'h003,0, 0, 0, 4'd0, 10'h000, 10'h003, 1, 0, 16'd3));
    // Collision: branch via 7 while writing 0x0AA to 7 uses the old 0x010.
    vq.push_back(mk(0, 9'h007,1, 0, 1, 4'd7, 10'h0AA, 10'h010, 1, 0, 16'd4));
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h011, 1, 0, 16'd5));
    vq.push_back(mk(0, 9'h007,1, 0, 0, 4'd0, 10'h000, 10'h0AA, 1, 0, 16'd6));
    vq.push_back(mk(0, 9'h1F7,1, 0, 1, 4'd7, 10'h3FF, 10'h0AA, 1, 0, 16'd7));
    vq.push_back(mk(0, 9'h007,1, 0, 0, 4'd0, 10'h000, 10'h3FF, 1, 0, 16'd8));
    // Increment from 0x3FF wraps; Start during RUN is ignored.
    vq.push_back(mk(0, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h000, 1, 0, 16'd9));
    vq.push_back(mk(1, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h001, 1, 0, 16'd10));
    vq.push_back(mk(1, HALT,  0, 0, 0, 4'd0, 10'h000, 10'h001, 0, 1, 16'd11));
    vq.push_back(mk(1, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h000, 1, 0, 16'd0));
    vq.push_back(mk(1, NOP,   0, 0, 0, 4'd0, 10'h000, 10'h001, 1, 0, 16'd1));

    for (int n = 0; n < vq.size(); n++) begin
      drive(vq[n].start, vq[n].instr, vq[n].br, vq[n].stl, vq[n].we, vq[n].idx, vq[n].tgt);
      tick();
      $display("[TB] vec %0d start=%0b instr=%h br=%0b stall=%0b -> pc=%h busy=%0b done=%0b cnt=%0d",
               n, vq[n].start, vq[n].instr, vq[n].br, vq[n].stl, pc1, busy1, done1, cnt1);
      check($sformatf("vec%0d_pc", n),   32'(pc1),   32'(vq[n].exp_pc));
      check($sformatf("vec%0d_busy", n), 32'(busy1), 32'(vq[n].exp_busy));
      check($sformatf("vec%0d_done", n), 32'(done1), 32'(vq[n].exp_done));
      check($sformatf("vec%0d_cnt", n),  32'(cnt1),  32'(vq[n].exp_cnt));
    end

    // Async reset between edges while running.
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    #2;
    Reset = 1'b1;
    #1;
    $display("[TB] async reset mid-run -> pc=%h busy=%0b done=%0b cnt=%0d", pc1, busy1, done1, cnt1);
    check("areset_pc",   32'(pc1),   32'd0);
    check("areset_busy", 32'(busy1), 32'd0);
    check("areset_cnt",  32'(cnt1),  32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Table must be cleared: branches via 7 and 3 both land on 0.
    drive(1'b1, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    drive(1'b0, 9'h007, 1'b1, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    $display("[TB] branch idx7 after reset -> pc=%h", pc1);
    check("cleared_idx7", 32'(pc1), 32'd0);
    drive(1'b0, 9'h003, 1'b1, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    $display("[TB] branch idx3 after reset -> pc=%h", pc1);
    check("cleared_idx3", 32'(pc1), 32'd0);
    drive(1'b0, HALT, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    check("halt2_done", 32'(done2), 32'd1);

    // Wrap from START_ADDR=0x3FF and 3-bit counter saturation.
    drive(1'b1, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    $display("[TB] wrap start -> pc2=%h cnt2=%0d", pc2, cnt2);
    check("wrap_start_pc", 32'(pc2), 32'h3FF);
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
    tick();
    $display("[TB] wrap step -> pc2=%h", pc2);
    check("wrap_next_pc", 32'(pc2), 32'h000);
    for (int k = 0; k < 9; k++) tick();
    $display("[TB] saturation -> cnt2=%0d cnt1=%0d pc1=%h", cnt2, cnt1, pc1);
    check("sat_cnt2", 32'(cnt2), 32'd7);
    check("run_cnt1", 32'(cnt1), 32'd10);
    check("run_pc1",  32'(pc1),  32'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
